// File: rtl/memory_arbiter_pkg.sv
// Shared state and grant types for the icache/dcache memory arbiter.
package memory_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } arb_state_t;

   typedef enum logic {
      GRANT_ICACHE,
      GRANT_DCACHE
   } grant_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Line-wide memory request port: addr/wr_data/write/valid out, rd_data/ready back.
// ready is a one-cycle completion pulse; rd_data is only meaningful while ready is high.
interface memory_interface #(
   parameter int ADDR_SIZE = 32,
   parameter int LINE_SIZE = 256
);

   logic [ADDR_SIZE-1:0] addr;
   logic [LINE_SIZE-1:0] wr_data;
   logic                 write;
   logic                 valid;
   logic [LINE_SIZE-1:0] rd_data;
   logic                 ready;

   modport master (
      output addr, wr_data, write, valid,
      input  rd_data, ready
   );

   modport slave (
      input  addr, wr_data, write, valid,
      output rd_data, ready
   );

endinterface

// File: rtl/memory_arbiter_rr_arbiter2.sv
// Two-way grant pick, purely combinational; on a tie either alternates against
// the previous winner or always favours the dcache.
module rr_arbiter2
   import memory_pkg::*;
(
   input  logic [1:0] i_req,
   input  grant_t     i_last_grant,
   input  logic       i_round_robin,
   output grant_t     o_grant
);

   // i_req[0] is the icache, i_req[1] the dcache
   always_comb begin
      o_grant = i_last_grant;
      case (i_req)
         2'b01:   o_grant = GRANT_ICACHE;
         2'b10:   o_grant = GRANT_DCACHE;
         2'b11: begin
            if (i_round_robin) begin
               o_grant = (i_last_grant == GRANT_ICACHE) ? GRANT_DCACHE : GRANT_ICACHE;
            end else begin
               o_grant = GRANT_DCACHE;
            end
         end
         default: o_grant = i_last_grant;
      endcase
   end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one backing memory between icache and dcache, one transaction at a time;
// uncontended completion DELAY+2 cycles after valid, loser is held off by keeping its ready low.
module memory_arbiter
   import memory_pkg::*;
#(
   parameter int ADDR_SIZE   = 32,
   parameter int LINE_SIZE   = 256,
   parameter int ROUND_ROBIN = 1
) (
   input  logic           clk_i,
   input  logic           reset_i,
   memory_interface.slave  icache_bus,
   memory_interface.slave  dcache_bus,
   memory_interface.master memory_bus
);

   arb_state_t           r_state;
   arb_state_t           w_next_state;
   grant_t               r_grant;
   grant_t               w_grant;
   logic [ADDR_SIZE-1:0] r_addr;
   logic [LINE_SIZE-1:0] r_wr_data;
   logic                 r_write;

   logic [1:0]           w_req;
   logic                 w_latch;
   logic                 w_mem_valid;
   logic                 w_done;
   logic                 w_pick_dcache;

   assign w_req = {dcache_bus.valid, icache_bus.valid};

   rr_arbiter2 u_rr_arbiter2 (
      .i_req         (w_req),
      .i_last_grant  (r_grant),
      .i_round_robin (ROUND_ROBIN != 0),
      .o_grant       (w_grant)
   );

   assign w_pick_dcache = (w_grant == GRANT_DCACHE);

   always_comb begin
      w_next_state = r_state;
      w_latch      = 1'b0;
      w_mem_valid  = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (|w_req) begin
               w_latch      = 1'b1;
               w_next_state = REQ;
            end
         end
         REQ: begin
            w_mem_valid = 1'b1;
            if (memory_bus.ready) begin
               w_next_state = WAIT;
            end
         end
         WAIT: begin
            // memory drops ready after accepting, so ready here means completion
            if (memory_bus.ready) begin
               w_done       = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // r_grant doubles as last_grant: it only changes when a new grant is made
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state   <= IDLE;
         r_grant   <= GRANT_DCACHE;
         r_addr    <= '0;
         r_wr_data <= '0;
         r_write   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_latch) begin
            r_grant   <= w_grant;
            r_addr    <= w_pick_dcache ? dcache_bus.addr    : icache_bus.addr;
            r_wr_data <= w_pick_dcache ? dcache_bus.wr_data : icache_bus.wr_data;
            r_write   <= w_pick_dcache ? dcache_bus.write   : icache_bus.write;
         end
      end
   end

   assign memory_bus.valid   = w_mem_valid;
   assign memory_bus.addr    = r_addr;
   assign memory_bus.wr_data = r_wr_data;
   assign memory_bus.write   = r_write;

   assign icache_bus.rd_data = memory_bus.rd_data;
   assign dcache_bus.rd_data = memory_bus.rd_data;
   assign icache_bus.ready   = w_done && (r_grant == GRANT_ICACHE);
   assign dcache_bus.ready   = w_done && (r_grant == GRANT_DCACHE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: two DUTs (round-robin and fixed priority), each with a
// line memory of delay 5 where line k starts as k, checked against a queue-based model.
module tb_memory_arbiter;
   import memory_pkg::*;

   localparam int AW     = 32;
   localparam int LW     = 256;
   localparam int DELAY  = 5;
   localparam int NLINES = 16;
   localparam int LAT    = DELAY + 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // requester k = 2*dut + side, side 0 = icache, side 1 = dcache
   memory_interface #(.ADDR_SIZE(AW), .LINE_SIZE(LW)) req_if [4] ();
   memory_interface #(.ADDR_SIZE(AW), .LINE_SIZE(LW)) mem_if [2] ();

   logic [AW-1:0] t_addr [4];
   logic [LW-1:0] t_wdat [4];
   logic          t_wr   [4];
   logic          t_vld  [4];
   logic          t_rdy  [4];
   logic [LW-1:0] t_rdat [4];
   logic          m_vld  [2];
   logic          m_wr   [2];
   logic [AW-1:0] m_addr [2];

   for (genvar k = 0; k < 4; k++) begin : g_req
      assign req_if[k].addr    = t_addr[k];
      assign req_if[k].wr_data = t_wdat[k];
      assign req_if[k].write   = t_wr[k];
      assign req_if[k].valid   = t_vld[k];
      assign t_rdy[k]          = req_if[k].ready;
      assign t_rdat[k]         = req_if[k].rd_data;
   end

   for (genvar g = 0; g < 2; g++) begin : g_dut
      memory_arbiter #(
         .ADDR_SIZE   (AW),
         .LINE_SIZE   (LW),
         .ROUND_ROBIN ((g == 0) ? 1 : 0)
      ) u_dut (
         .clk_i      (clk),
         .reset_i    (reset),
         .icache_bus (req_if[2*g]),
         .dcache_bus (req_if[2*g+1]),
         .memory_bus (mem_if[g])
      );

      logic [LW-1:0] mem [NLINES];
      int            cnt;
      logic          loaded = 1'b0;

      assign mem_if[g].ready   = (cnt == 0);
      assign mem_if[g].rd_data = mem[mem_if[g].addr[8:5]];
      assign m_vld[g]          = mem_if[g].valid;
      assign m_wr[g]           = mem_if[g].write;
      assign m_addr[g]         = mem_if[g].addr;

      always @(posedge clk) begin
         if (!loaded) begin
            for (int i = 0; i < NLINES; i++) mem[i] <= LW'(i);
            loaded <= 1'b1;
         end
         if (reset) begin
            cnt <= 0;
         end else if (mem_if[g].valid && cnt == 0) begin
            cnt <= DELAY;
            if (mem_if[g].write) mem[mem_if[g].addr[8:5]] <= mem_if[g].wr_data;
         end else if (cnt != 0) begin
            cnt <= cnt - 1;
         end
      end
   end

   int            n_assert = 0;
   int            n_fail   = 0;
   logic [LW-1:0] ref_mem  [2][NLINES];
   int            ref_last [2];        // 0 = icache, 1 = dcache
   int            done_t   [2][8];

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One uncontended transaction from requester (g, s).
   task automatic single(input int g, input int s, input logic [AW-1:0] a, input logic w,
                         input logic [LW-1:0] d, input string tag);
      int            k = 2*g + s;
      int            o = 2*g + (1 - s);
      int            lat = 0;
      int            other = 0;
      bit            got = 0;
      logic [LW-1:0] rd = '0;
      t_addr[k] = a; t_wr[k] = w; t_wdat[k] = d; t_vld[k] = 1'b1;
      while (!got && lat < 60) begin
         @(negedge clk);
         lat++;
         if (t_rdy[o]) other++;
         if (t_rdy[k]) begin
            got = 1;
            rd  = t_rdat[k];
         end
      end
      @(negedge clk);
      check({tag, "_pulse_width"}, LW'(t_rdy[k]), LW'(0));
      t_vld[k] = 1'b0;
      check({tag, "_latency"}, LW'(lat), LW'(LAT));
      check({tag, "_loser_ready"}, LW'(other), LW'(0));
      if (!w) check({tag, "_rd_data"}, rd, ref_mem[g][a[8:5]]);
      else    ref_mem[g][a[8:5]] = d;
      ref_last[g] = s;
   endtask

   // Both requesters hold valid continuously over ni / nd random requests.
   task automatic run_both(input int g, input int ni, input int nd, input string tag);
      int            n[2];
      int            idx[2];
      int            r[2];
      bit            pend[2];
      int            exp_order[$];
      int            act_order[$];
      logic [AW-1:0] qa[2][8];
      logic          qw[2][8];
      logic [LW-1:0] qd[2][8];
      int            last = ref_last[g];
      int            cyc = 0;
      int            pick;
      n[0] = ni; n[1] = nd;
      for (int s = 0; s < 2; s++) begin
         idx[s] = 0; pend[s] = 0; r[s] = n[s];
         for (int i = 0; i < n[s]; i++) begin
            qa[s][i] = {23'd0, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31))};
            qw[s][i] = ($urandom_range(0, 2) == 0);
            qd[s][i] = {8{$urandom()}};
         end
      end
      while (r[0] + r[1] > 0) begin
         if (r[0] > 0 && r[1] > 0) pick = (g == 0) ? (1 - last) : 1;
         else                      pick = (r[0] > 0) ? 0 : 1;
         exp_order.push_back(pick);
         r[pick]--;
         last = pick;
      end
      for (int s = 0; s < 2; s++) begin
         if (n[s] > 0) begin
            t_addr[2*g+s] = qa[s][0]; t_wr[2*g+s] = qw[s][0];
            t_wdat[2*g+s] = qd[s][0]; t_vld[2*g+s] = 1'b1;
         end
      end
      while ((idx[0] < n[0] || idx[1] < n[1] || pend[0] || pend[1]) && cyc < 600) begin
         @(negedge clk);
         cyc++;
         for (int s = 0; s < 2; s++) begin
            if (pend[s]) begin
               pend[s] = 0;
               if (idx[s] < n[s]) begin
                  t_addr[2*g+s] = qa[s][idx[s]]; t_wr[2*g+s] = qw[s][idx[s]];
                  t_wdat[2*g+s] = qd[s][idx[s]];
               end else begin
                  t_vld[2*g+s] = 1'b0;
               end
            end else if (t_rdy[2*g+s] && idx[s] < n[s]) begin
               if (!qw[s][idx[s]])
                  check({tag, "_rd_data"}, t_rdat[2*g+s], ref_mem[g][qa[s][idx[s]][8:5]]);
               else
                  ref_mem[g][qa[s][idx[s]][8:5]] = qd[s][idx[s]];
               done_t[s][idx[s]] = cyc;
               act_order.push_back(s);
               idx[s]++;
               pend[s] = 1;
            end
         end
      end
      t_vld[2*g] = 1'b0; t_vld[2*g+1] = 1'b0;
      ref_last[g] = last;
      check({tag, "_count"}, LW'(act_order.size()), LW'(exp_order.size()));
      for (int i = 0; i < exp_order.size(); i++) begin
         check({tag, "_grant_order"}, (i < act_order.size()) ? LW'(act_order[i]) : 'x,
               LW'(exp_order[i]));
      end
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) t_vld[k] = 1'b0;
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
      ref_last[0] = 1; ref_last[1] = 1;
   endtask

   initial begin
      int            n_pulse;
      int            lat;
      bit            got;
      logic [LW-1:0] rd;
      for (int k = 0; k < 4; k++) begin
         t_vld[k] = 1'b0; t_wr[k] = 1'b0; t_addr[k] = '0; t_wdat[k] = '0;
      end
      for (int g = 0; g < 2; g++)
         for (int i = 0; i < NLINES; i++) ref_mem[g][i] = LW'(i);
      ref_last[0] = 1; ref_last[1] = 1;

      reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check("reset_mem_valid", LW'(m_vld[g]), LW'(0));
         check("reset_mem_write", LW'(m_wr[g]), LW'(0));
         check("reset_mem_addr", LW'(m_addr[g]), LW'(0));
         check("reset_icache_ready", LW'(t_rdy[2*g]), LW'(0));
         check("reset_dcache_ready", LW'(t_rdy[2*g+1]), LW'(0));
      end
      reset = 1'b0;
      @(negedge clk);

      single(0, 0, 32'h40, 1'b0, '0, "icache_read_0x40");
      single(0, 1, 32'h20, 1'b1, {32{8'hAB}}, "dcache_write_0x20");
      single(0, 1, 32'h20, 1'b0, '0, "dcache_read_0x20");
      check("dcache_readback_AB", ref_mem[0][1], {32{8'hAB}});

      // simultaneous requests straight after reset: icache first, then dcache
      do_reset(2);
      run_both(0, 1, 1, "tie_after_reset");
      check("tie_icache_done", LW'(done_t[0][0]), LW'(LAT));
      check("tie_dcache_done", LW'(done_t[1][0]), LW'(LAT + 1 + LAT));

      run_both(0, 3, 3, "rr_alternate");
      run_both(1, 2, 3, "fixed_prio");

      // reset while the memory transaction is outstanding
      t_addr[0] = 32'h60; t_wr[0] = 1'b0; t_vld[0] = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1; t_vld[0] = 1'b0;
      @(negedge clk);
      check("reset_wait_mem_valid", LW'(m_vld[0]), LW'(0));
      reset = 1'b0;
      ref_last[0] = 1; ref_last[1] = 1;
      n_pulse = 0;
      repeat (10) begin
         @(negedge clk);
         if (t_rdy[0] || t_rdy[1]) n_pulse++;
      end
      check("reset_wait_no_pulse", LW'(n_pulse), LW'(0));
      single(0, 0, 32'h60, 1'b0, '0, "after_reset_read");

      // requester address changes while the read is in flight
      t_addr[1] = 32'h80; t_wr[1] = 1'b0; t_vld[1] = 1'b1;
      lat = 0; got = 0; rd = '0;
      while (!got && lat < 60) begin
         @(negedge clk);
         lat++;
         if (lat == 3) t_addr[1] = 32'h1A0;
         if (lat == 5) check("addr_hold_mem_addr", LW'(m_addr[0]), LW'(32'h80));
         if (t_rdy[1]) begin
            got = 1;
            rd  = t_rdat[1];
         end
      end
      @(negedge clk);
      t_vld[1] = 1'b0;
      ref_last[0] = 1;
      check("addr_hold_latency", LW'(lat), LW'(LAT));
      check("addr_hold_rd_data", rd, ref_mem[0][4]);

      for (int i = 0; i < 12; i++) begin
         single(0, int'($urandom_range(0, 1)),
                {23'd0, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31))},
                1'($urandom_range(0, 1)), {8{$urandom()}}, "random_single");
      end
      for (int i = 0; i < 3; i++)
         run_both(0, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), "random_rr");
      run_both(1, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), "random_fixed");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d assertions evaluated", n_assert);
      $fatal(1, "watchdog expired");
   end

endmodule
